// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl -- PUSH/POP sequencer for the 16-bit stack pointer register.
//
// The stack is empty-descending: PUSH writes mem[SP] and then pulses sp_dec.
// POP reads mem[SP+1] and then pulses sp_inc. Each operation is one memory
// request on a req/ack port. The request is aborted if mem_ack does not
// arrive within WAIT_MAX cycles.
//
// Optional feature macro: STACK_CTRL_BOUNDS_EN
//   When it is defined, the STACK_TOP and STACK_LIMIT parameters and the
//   fault_ovf output are added. Out-of-range requests fault at accept.
//   When it is undefined, only a timeout can set err.
//
// Handshakes (the only protocol rules in this block):
//   * Caller side: req/op/push_data are sampled only in IDLE. The posedge
//     with req=1 in IDLE is the accept. A req seen while busy is dropped,
//     not queued, so the caller must re-assert it.
//   * Memory side: mem_we/mem_re act as "valid" and mem_ack acts as
//     "ready". A request stays asserted with stable mem_addr and mem_wdata
//     until the cycle in which mem_ack=1 is sampled, or until the timeout.
//     mem_rdata is taken in the mem_ack cycle. mem_ack is ignored in every
//     other state.
//
// Ports:
//   clk        in   system clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   req, op    in   request / 0=PUSH 1=POP
//   push_data  in   PUSH data, captured at accept
//   busy       out  high from accept+1 through the done cycle
//   done, err  out  one-cycle completion pulse / error flag (valid with done)
//   pop_data   out  last successful POP result
//   sp_val     in   current SP value
//   sp_inc     out  one-cycle SP increment strobe (POP success)
//   sp_dec     out  one-cycle SP decrement strobe (PUSH success)
//   mem_*           stack memory request port
//   fault_ovf  out  sticky PUSH bounds fault (only with STACK_CTRL_BOUNDS_EN)
//   state_dbg  out  current FSM state (0 IDLE, 1 PUSH_WR, 2 POP_RD, 3 FIN)
// -----------------------------------------------------------------------------
module stack_ctrl #(
  parameter int unsigned WAIT_MAX = 16
`ifdef STACK_CTRL_BOUNDS_EN
  ,
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hF000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        op,
  input  logic [15:0] push_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pop_data,
  input  logic [15:0] sp_val,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
`ifdef STACK_CTRL_BOUNDS_EN
  output logic        fault_ovf,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_WR = 2'd1,
    POP_RD  = 2'd2,
    FIN     = 2'd3
  } state_t;

  // Timeout is taken when the counter already shows WAIT_MAX-1 non-ack
  // cycles and the current cycle also has no ack. The request is therefore
  // held for exactly WAIT_MAX cycles.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] pop_data_q, pop_data_d;
  logic        sp_inc_q, sp_inc_d;
  logic        sp_dec_q, sp_dec_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bound_fault;
`ifdef STACK_CTRL_BOUNDS_EN
  logic        fault_ovf_q, fault_ovf_d;
`endif

  // Bounds check on the live sp_val at accept. A POP reads SP+1, so SP at
  // or above the top would read past the stack.
`ifdef STACK_CTRL_BOUNDS_EN
  assign bound_fault = op ? (sp_val >= STACK_TOP) : (sp_val < STACK_LIMIT);
`else
  assign bound_fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    pop_data_d  = pop_data_q;
    sp_inc_d    = 1'b0;
    sp_dec_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    cnt_d       = cnt_q;
`ifdef STACK_CTRL_BOUNDS_EN
    fault_ovf_d = fault_ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req) begin
          busy_d      = 1'b1;
          cnt_d       = 8'd0;
          mem_wdata_d = push_data;
          // POP address wraps naturally: SP=FFFF reads 0000.
          mem_addr_d  = op ? (sp_val + 16'd1) : sp_val;
          if (bound_fault) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
`ifdef STACK_CTRL_BOUNDS_EN
            if (!op) fault_ovf_d = 1'b1;
`endif
          end else if (op) begin
            state_d  = POP_RD;
            mem_re_d = 1'b1;
          end else begin
            state_d  = PUSH_WR;
            mem_we_d = 1'b1;
          end
        end
      end

      PUSH_WR, POP_RD: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          mem_re_d = 1'b0;
          state_d  = FIN;
          done_d   = 1'b1;
          if (state_q == POP_RD) begin
            sp_inc_d   = 1'b1;
            pop_data_d = mem_rdata;
          end else begin
            sp_dec_d = 1'b1;
          end
        end else if (cnt_q == WAIT_LAST) begin
          mem_we_d = 1'b0;
          mem_re_d = 1'b0;
          state_d  = FIN;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pop_data_q  <= 16'd0;
      sp_inc_q    <= 1'b0;
      sp_dec_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cnt_q       <= 8'd0;
`ifdef STACK_CTRL_BOUNDS_EN
      fault_ovf_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      pop_data_q  <= pop_data_d;
      sp_inc_q    <= sp_inc_d;
      sp_dec_q    <= sp_dec_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cnt_q       <= cnt_d;
`ifdef STACK_CTRL_BOUNDS_EN
      fault_ovf_q <= fault_ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pop_data  = pop_data_q;
  assign sp_inc    = sp_inc_q;
  assign sp_dec    = sp_dec_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign state_dbg = state_q;
`ifdef STACK_CTRL_BOUNDS_EN
  assign fault_ovf = fault_ovf_q;
`endif

endmodule
